// File: rtl/mult_state_sequencer.sv
// mult_state_sequencer: present-state register and next-state logic for the 4x4 multiplier controller.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   level request, sampled only in IDLE
//   mbit   in   current multiplier LSB, sampled when leaving SETUP or STORE
//   abort  in   cancel request (only when SEQ_ABORT_EN is defined)
//   ps     out  3-bit present-state code to the signal-assigner
//   busy   out  high whenever ps != 000
//   done   out  one-cycle completion pulse, coincides with ps returning to 000
//   iter   out  completed-iteration count
//
// Optional feature macro: SEQ_ABORT_EN adds the abort port.

package mult_state_sequencer_pkg;
    // Codes are fixed: the downstream decoder depends on them bit-for-bit.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_CLR   = 3'b001,
        ST_LOAD1 = 3'b010,
        ST_SETUP = 3'b011,
        ST_ADD   = 3'b100,
        ST_SHIFT = 3'b101,
        ST_STORE = 3'b110,
        ST_ILL   = 3'b111
    } state_e;
endpackage

module mult_state_sequencer
    import mult_state_sequencer_pkg::*;
#(
    parameter int ITER = 4,
    localparam int CW = $clog2(ITER + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mbit,
`ifdef SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic [2:0]    ps,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter
);

    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic [CW-1:0] FULL = CW'(ITER);

    state_e        state_q, state_d;
    logic [CW-1:0] iter_q, iter_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_CLR : ST_IDLE;
            ST_CLR:   state_d = ST_LOAD1;
            ST_LOAD1: begin
                state_d = ST_SETUP;
                iter_d  = '0;
            end
            ST_SETUP: state_d = mbit ? ST_ADD : ST_SHIFT;
            ST_ADD:   state_d = ST_SHIFT;
            ST_SHIFT: state_d = ST_STORE;
            ST_STORE: begin
                if (iter_q == LAST) begin
                    state_d = ST_IDLE;
                    iter_d  = FULL;
                    done_d  = 1'b1;
                end else begin
                    // Next iteration: skip the add step when the new LSB is 0.
                    state_d = mbit ? ST_ADD : ST_SHIFT;
                    iter_d  = iter_q + CW'(1);
                end
            end
            default:  state_d = ST_IDLE;
        endcase
`ifdef SEQ_ABORT_EN
        // Abort wins over every transition while busy; in IDLE start keeps priority.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            iter_d  = iter_q;
            done_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            done_q  <= done_d;
        end
    end

    assign ps   = state_q;
    assign busy = state_q != ST_IDLE;
    assign done = done_q;
    assign iter = iter_q;

endmodule
